pi_stream_tx: RTL and testbench

Buffered downstream transmitter that carries processed samples from the effects stage to the Raspberry Pi over SPI, with the FPGA as master. It accepts one 11-bit sign-magnitude sample per strobe at 48 kHz into a small FIFO. Each sample is sent as a self-describing 16-bit frame with a start marker, sequence number and parity. The FIFO absorbs jitter between the sample clock and frame transmission. Overflow is detected and reported rather than silently lost.

---
 rtl/pi_stream_tx_if.sv | 27 ++
 rtl/pi_stream_tx.sv | 173 +++++++++++++++++
 tb/tb_pi_stream_tx.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pi_stream_tx_if.sv
// Sample input, SPI and status signals of pi_stream_tx. The transmitter is the
// SPI master and takes modport master; the sample producer/Pi side takes slave.
interface pi_stream_tx_if #(
  parameter int DEPTH = 8
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic          sample_valid;
  logic [10:0]   sample;
  logic          clear_overflow;
  logic          sclk;
  logic          dout;
  logic          ncs;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic [7:0]    drop_count;

  modport master (
    input  sample_valid, sample, clear_overflow,
    output sclk, dout, ncs, fifo_level, overflow, drop_count
  );

  modport slave (
    output sample_valid, sample, clear_overflow,
    input  sclk, dout, ncs, fifo_level, overflow, drop_count
  );
endinterface

// File: rtl/pi_stream_tx.sv
// Buffered SPI-master transmitter: queues {seq, sample} entries in a small FIFO
// and sends each as a 16-bit frame (start bit, seq, sample, even parity).
module pi_stream_tx #(
  parameter int DEPTH    = 8,
  parameter int CLK_DIV  = 16,
  parameter int GAP_BITS = 2
) (
  input  logic           clk,
  input  logic           nreset,
  pi_stream_tx_if.master bus
);
  localparam int PW       = $clog2(DEPTH);
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int BIT_CLKS = 2 * CLK_DIV;
  localparam int GAP_CLKS = GAP_BITS * BIT_CLKS;
  localparam int GAP_LAST = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
  localparam int CNT_MAX  = (GAP_CLKS > BIT_CLKS) ? GAP_CLKS : BIT_CLKS;
  localparam int CW       = $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t        state_q;
  logic [CW-1:0] div_q;
  logic [3:0]    bit_q;
  logic [15:0]   shift_q;
  logic          sclk_q;
  logic          dout_q;
  logic          ncs_q;

  logic [2:0]    seq_q;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;
  logic [13:0]   mem [DEPTH];

  logic          pop;
  logic          push;
  logic          drop;
  logic [13:0]   head;
  logic [15:0]   frame;

  assign head  = mem[rptr_q];
  assign frame = {1'b1, head, ^{1'b1, head}};

  // A full FIFO still accepts a sample when the head is popped in the same cycle.
  always_comb begin
    pop        = (state_q == LOAD);
    push       = bus.sample_valid && ((level_q < LW'(DEPTH)) || pop);
    drop       = bus.sample_valid && !push;

    level_d    = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end

    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.clear_overflow) begin
        drop_d = 8'd1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (bus.clear_overflow) begin
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= {seq_q, bus.sample};
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seq_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (bus.sample_valid) begin
        seq_q <= seq_q + 3'd1;
      end
      if (push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // sclk rises halfway through each bit; dout only moves on the falling edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      dout_q  <= 1'b0;
      ncs_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          ncs_q  <= 1'b1;
          sclk_q <= 1'b0;
          dout_q <= 1'b0;
          div_q  <= '0;
          if (level_q != '0) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          shift_q <= {frame[14:0], 1'b0};
          dout_q  <= frame[15];
          ncs_q   <= 1'b0;
          div_q   <= '0;
          bit_q   <= 4'd15;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (div_q == CW'(BIT_CLKS - 1)) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            if (bit_q == 4'd0) begin
              ncs_q   <= 1'b1;
              dout_q  <= 1'b0;
              state_q <= GAP;
            end else begin
              bit_q   <= bit_q - 4'd1;
              dout_q  <= shift_q[15];
              shift_q <= {shift_q[14:0], 1'b0};
            end
          end else begin
            div_q <= div_q + CW'(1);
            if (div_q == CW'(CLK_DIV - 1)) begin
              sclk_q <= 1'b1;
            end
          end
        end
        GAP: begin
          if (div_q == CW'(GAP_LAST)) begin
            div_q   <= '0;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.dout       = dout_q;
  assign bus.ncs        = ncs_q;
  assign bus.fifo_level = level_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_pi_stream_tx.sv
// Directed bench for pi_stream_tx: an SPI capture monitor collects complete
// frames, and per-scenario tasks compare them against hand-derived values.
`timescale 1ns/1ps
module tb_pi_stream_tx;
  localparam int DEPTH    = 8;
  localparam int CLK_DIV  = 16;
  localparam int GAP_BITS = 2;

  logic clk = 1'b0;
  logic nreset;

  pi_stream_tx_if #(.DEPTH(DEPTH)) bus ();

  pi_stream_tx #(
    .DEPTH   (DEPTH),
    .CLK_DIV (CLK_DIV),
    .GAP_BITS(GAP_BITS)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus)
  );

  always #12.5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] rxShift = '0;
  int          rxBits  = 0;
  logic [15:0] rxFrames[$];
  int          partialFrames = 0;
  int          sclkEdges     = 0;
  int          sclkWhileIdle = 0;

  // Only complete 16-bit frames are kept; a frame cut short by ncs counts as partial.
  always @(posedge bus.sclk or posedge bus.ncs) begin
    if (bus.ncs === 1'b1) begin
      if (rxBits == 16) begin
        rxFrames.push_back(rxShift);
      end else if (rxBits != 0) begin
        partialFrames++;
      end
      rxBits = 0;
    end else begin
      rxShift = {rxShift[14:0], bus.dout};
      rxBits++;
    end
  end

  always @(posedge bus.sclk) begin
    sclkEdges++;
    if (bus.ncs !== 1'b0) begin
      sclkWhileIdle++;
    end
  end

  function automatic logic [15:0] makeFrame(input logic [2:0] seq, input logic [10:0] s);
    logic [14:0] body;
    body = {1'b1, seq, s};
    return {body, ^body};
  endfunction

  task automatic doReset();
    bus.sample_valid   = 1'b0;
    bus.sample         = '0;
    bus.clear_overflow = 1'b0;
    @(negedge clk);
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pushSample(input logic [10:0] s);
    bus.sample       = s;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic waitFrames(input int target, input int budget, output bit timedOut);
    int n;
    n = 0;
    while (rxFrames.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    timedOut = (rxFrames.size() < target);
  endtask

  task automatic test_reset();
    bus.sample_valid   = 1'b0;
    bus.sample         = '0;
    bus.clear_overflow = 1'b0;
    nreset = 1'b0;
    #30;
    compared++; if (bus.sclk !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sclk got %b want 0", bus.sclk); end
    compared++; if (bus.dout !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dout got %b want 0", bus.dout); end
    compared++; if (bus.ncs !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ncs got %b want 1", bus.ncs); end
    compared++; if (bus.fifo_level !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_level got %0d want 0", bus.fifo_level); end
    compared++; if (bus.overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overflow got %b want 0", bus.overflow); end
    compared++; if (bus.drop_count !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_drop got %0d want 0", bus.drop_count); end
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_sample();
    int  base;
    int  cnt;
    bit  to;
    base = rxFrames.size();
    pushSample(11'h7FF);
    compared++; if (bus.fifo_level !== 4'd1) begin mismatched++; $display("[TB] FAIL single_level got %0d want 1", bus.fifo_level); end
    cnt = 0;
    while (bus.ncs === 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    compared++; if (cnt != 2) begin mismatched++; $display("[TB] FAIL single_ncs_latency got %0d want 2", cnt); end
    cnt = 0;
    while (bus.ncs === 1'b0 && cnt < 2000) begin @(negedge clk); cnt++; end
    compared++; if (cnt != 512) begin mismatched++; $display("[TB] FAIL single_ncs_low_clks got %0d want 512", cnt); end
    waitFrames(base + 1, 10, to);
    compared++; if (to) begin mismatched++; $display("[TB] FAIL single_frame_count got %0d want %0d", rxFrames.size(), base + 1); end
    if (!to) begin
      // 1,000,1,1111111111 has twelve ones, so the even-parity bit is 0.
      compared++; if (rxFrames[base] !== 16'h8FFE) begin mismatched++; $display("[TB] FAIL single_frame got %h want 8ffe", rxFrames[base]); end
    end
  endtask

  task automatic test_sign_parity();
    int base;
    bit to;
    doReset();
    base = rxFrames.size();
    bus.sample_valid = 1'b1;
    bus.sample       = 11'h400;
    @(negedge clk);
    bus.sample       = 11'h001;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    compared++; if (bus.fifo_level !== 4'd2) begin mismatched++; $display("[TB] FAIL sign_level got %0d want 2", bus.fifo_level); end
    waitFrames(base + 2, 2000, to);
    compared++; if (to) begin mismatched++; $display("[TB] FAIL sign_frame_count got %0d want %0d", rxFrames.size(), base + 2); end
    if (!to) begin
      compared++; if (rxFrames[base] !== 16'h8800) begin mismatched++; $display("[TB] FAIL sign_neg_zero got %h want 8800", rxFrames[base]); end
      compared++; if (rxFrames[base+1] !== 16'h9003) begin mismatched++; $display("[TB] FAIL sign_seq1 got %h want 9003", rxFrames[base+1]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    int partial0;
    int edges0;
    int ncsLow;
    int cnt;
    bit to;
    doReset();
    base     = rxFrames.size();
    partial0 = partialFrames;
    pushSample(11'h2AB);
    cnt = 0;
    while (rxBits < 5 && cnt < 1000) begin @(negedge clk); cnt++; end
    compared++; if (rxBits != 5) begin mismatched++; $display("[TB] FAIL midreset_reach_bit5 got %0d want 5", rxBits); end
    #3;
    nreset = 1'b0;
    #1;
    compared++; if (bus.ncs !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_async_ncs got %b want 1", bus.ncs); end
    compared++; if (bus.sclk !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_async_sclk got %b want 0", bus.sclk); end
    repeat (3) @(negedge clk);
    compared++; if (bus.fifo_level !== 4'd0) begin mismatched++; $display("[TB] FAIL midreset_level got %0d want 0", bus.fifo_level); end
    nreset = 1'b1;
    edges0 = sclkEdges;
    ncsLow = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.ncs !== 1'b1) ncsLow++;
    end
    compared++; if (sclkEdges != edges0) begin mismatched++; $display("[TB] FAIL midreset_quiet_sclk got %0d edges want 0", sclkEdges - edges0); end
    compared++; if (ncsLow != 0) begin mismatched++; $display("[TB] FAIL midreset_quiet_ncs got %0d low clks want 0", ncsLow); end
    compared++; if (partialFrames != partial0 + 1) begin mismatched++; $display("[TB] FAIL midreset_partial got %0d want %0d", partialFrames, partial0 + 1); end
    compared++; if (rxFrames.size() != base) begin mismatched++; $display("[TB] FAIL midreset_no_resend got %0d want %0d", rxFrames.size(), base); end
    pushSample(11'h155);
    waitFrames(base + 1, 1000, to);
    compared++; if (to) begin mismatched++; $display("[TB] FAIL midreset_next_count got %0d want %0d", rxFrames.size(), base + 1); end
    if (!to) begin
      compared++; if (rxFrames[base] !== 16'h82AA) begin mismatched++; $display("[TB] FAIL midreset_seq0_frame got %h want 82aa", rxFrames[base]); end
    end
  endtask

  task automatic test_steady_stream();
    int          base;
    int          peak;
    int          sawOverflow;
    bit          to;
    logic [10:0] sent[$];
    logic [10:0] s;
    doReset();
    base        = rxFrames.size();
    peak        = 0;
    sawOverflow = 0;
    for (int i = 0; i < 40; i++) begin
      s = 11'((i * 173 + 5) % 2048);
      sent.push_back(s);
      pushSample(s);
      repeat (832) begin
        @(negedge clk);
        if (int'(bus.fifo_level) > peak) peak = int'(bus.fifo_level);
        if (bus.overflow !== 1'b0) sawOverflow++;
      end
    end
    waitFrames(base + 40, 1500, to);
    compared++; if (to) begin mismatched++; $display("[TB] FAIL steady_count got %0d want %0d", rxFrames.size() - base, 40); end
    if (!to) begin
      for (int i = 0; i < 40; i++) begin
        compared++;
        if (rxFrames[base+i] !== makeFrame(3'(i % 8), sent[i])) begin
          mismatched++;
          $display("[TB] FAIL steady_frame[%0d] got %h want %h", i, rxFrames[base+i], makeFrame(3'(i % 8), sent[i]));
        end
      end
    end
    compared++; if (peak > 1) begin mismatched++; $display("[TB] FAIL steady_peak_level got %0d want <=1", peak); end
    compared++; if (sawOverflow != 0) begin mismatched++; $display("[TB] FAIL steady_overflow got %0d clks want 0", sawOverflow); end
  endtask

  task automatic test_overflow();
    int          base;
    int          peak;
    int          cnt;
    logic [10:0] vals[12];
    doReset();
    base = rxFrames.size();
    peak = 0;
    for (int i = 0; i < 12; i++) vals[i] = 11'(16 * i + 3);
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.sample = vals[i];
      @(negedge clk);
      if (int'(bus.fifo_level) > peak) peak = int'(bus.fifo_level);
    end
    bus.sample_valid = 1'b0;
    compared++; if (bus.drop_count !== 8'd3) begin mismatched++; $display("[TB] FAIL ovf_drop_count got %0d want 3", bus.drop_count); end
    compared++; if (bus.overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_flag got %b want 1", bus.overflow); end
    compared++; if (bus.fifo_level !== 4'd8) begin mismatched++; $display("[TB] FAIL ovf_level got %0d want 8", bus.fifo_level); end
    cnt = 0;
    while (rxFrames.size() < base + 9 && cnt < 7000) begin
      @(negedge clk);
      cnt++;
      if (int'(bus.fifo_level) > peak) peak = int'(bus.fifo_level);
    end
    repeat (700) @(negedge clk);
    compared++; if (rxFrames.size() != base + 9) begin mismatched++; $display("[TB] FAIL ovf_frame_count got %0d want 9", rxFrames.size() - base); end
    if (rxFrames.size() >= base + 9) begin
      for (int i = 0; i < 9; i++) begin
        compared++;
        if (rxFrames[base+i] !== makeFrame(3'(i % 8), vals[i])) begin
          mismatched++;
          $display("[TB] FAIL ovf_frame[%0d] got %h want %h", i, rxFrames[base+i], makeFrame(3'(i % 8), vals[i]));
        end
      end
    end
    compared++; if (peak != 8) begin mismatched++; $display("[TB] FAIL ovf_peak_level got %0d want 8", peak); end
  endtask

  task automatic test_simultaneous();
    int base;
    int cnt;
    bit to;
    doReset();
    base = rxFrames.size();
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.sample = 11'(i + 100);
      @(negedge clk);
    end
    bus.sample_valid = 1'b0;
    compared++; if (bus.fifo_level !== 4'd8) begin mismatched++; $display("[TB] FAIL sim_full_level got %0d want 8", bus.fifo_level); end
    compared++; if (bus.overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_no_overflow got %b want 0", bus.overflow); end
    pushSample(11'h011);
    compared++; if (bus.drop_count !== 8'd1) begin mismatched++; $display("[TB] FAIL sim_first_drop got %0d want 1", bus.drop_count); end
    bus.clear_overflow = 1'b1;
    pushSample(11'h022);
    bus.clear_overflow = 1'b0;
    compared++; if (bus.overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL sim_clear_drop_flag got %b want 1", bus.overflow); end
    compared++; if (bus.drop_count !== 8'd1) begin mismatched++; $display("[TB] FAIL sim_clear_drop_count got %0d want 1", bus.drop_count); end
    cnt = 0;
    while (bus.ncs === 1'b0 && cnt < 1000) begin @(negedge clk); cnt++; end
    // ncs rose one edge ago: 64 gap clks plus one IDLE clk puts the next cycle in LOAD.
    repeat (65) @(negedge clk);
    compared++; if (bus.fifo_level !== 4'd8) begin mismatched++; $display("[TB] FAIL sim_pre_load_level got %0d want 8", bus.fifo_level); end
    pushSample(11'h0AA);
    compared++; if (bus.fifo_level !== 4'd8) begin mismatched++; $display("[TB] FAIL sim_load_push_level got %0d want 8", bus.fifo_level); end
    compared++; if (bus.drop_count !== 8'd1) begin mismatched++; $display("[TB] FAIL sim_load_push_accepted got %0d drops want 1", bus.drop_count); end
    waitFrames(base + 10, 6000, to);
    compared++; if (to) begin mismatched++; $display("[TB] FAIL sim_frame_count got %0d want 10", rxFrames.size() - base); end
    if (!to) begin
      compared++; if (rxFrames[base+9] !== makeFrame(3'd3, 11'h0AA)) begin mismatched++; $display("[TB] FAIL sim_last_frame got %h want %h", rxFrames[base+9], makeFrame(3'd3, 11'h0AA)); end
    end
    bus.clear_overflow = 1'b1;
    @(negedge clk);
    bus.clear_overflow = 1'b0;
    compared++; if (bus.overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_clear_flag got %b want 0", bus.overflow); end
    compared++; if (bus.drop_count !== 8'd0) begin mismatched++; $display("[TB] FAIL sim_clear_count got %0d want 0", bus.drop_count); end
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_sign_parity();
    test_reset_mid_frame();
    test_steady_stream();
    test_overflow();
    test_simultaneous();
    compared++; if (sclkWhileIdle != 0) begin mismatched++; $display("[TB] FAIL sclk_while_ncs_high got %0d want 0", sclkWhileIdle); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
